alu_issue: RTL
==============

# alu_issue

Operand-fetch and issue stage sitting directly upstream of the registered ALU + result-register pair. It accepts 3-operand ALU instructions over a valid/ready handshake and reads operands from an internal register file. It drives `R2`/`R3`/`ALUOp` into the ALU and writes the returned `R0` and flags back at a fixed latency. A scoreboard stalls issue on read-after-write hazards; there is no bypass path.

## Interface
- `WIDTH`, 32, datapath width (matches ALU)
- `AW`, 3, register address width; `NREGS = 2**AW`
- `LAT`, 2, register stages between `R2`/`R3` and `R0` in the downstream ALU + result register
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  reset; synchronous and active-high, with one clock
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  instruction accepted this edge when high with `instr_valid`
- `instr_op`  in  3  ALU opcode, passed through unchanged
- `instr_rd`, `instr_rs`, `instr_rt`  in  AW  destination and source register indices
- `ld_valid`  in  1  direct register load request
- `ld_ready`  out  1  load accepted this edge
- `ld_addr`  in  AW  load target
- `ld_data`  in  WIDTH  load value
- `R2`, `R3`  out  WIDTH  operands to the ALU (registered)
- `ALUOp`  out  3  opcode to the ALU (registered)
- `R0`  in  WIDTH  result returned from downstream
- `overflow`, `zero`, `carry`  in  1  flags returned from downstream
- `status`  out  3  last written-back flags `{overflow, zero, carry}`
- `busy`  out  1  any instruction in flight
- `dbg_addr`  in  AW  debug read address
- `dbg_data`  out  WIDTH  combinational read of `rf[dbg_addr]`

## Operation
- Register file `rf[0..NREGS-1]`, WIDTH bits each.
  - Reading `rf[0]` always returns 0.
  - Writes to index 0 are dropped, and a destination of 0 never creates a hazard.
- In-flight tracker: a shift register of depth `LAT+1`, each entry `{v, rd}`, shifting every cycle. Entry 0 is loaded at issue.
- Issue handshake: when `instr_valid && instr_ready`:
  - `R2 <= rf[rs]`, `R3 <= rf[rt]`, `ALUOp <= instr_op`
  - entry 0 `<= {1, rd}`
- Otherwise entry 0 `<= {0, x}`. `R2`/`R3`/`ALUOp` hold their values; downstream results for non-issued cycles are ignored.
- `instr_ready = !rst && !hazard`.
  - `hazard` is true if any valid entry has a non-zero `rd` equal to `instr_rs` or `instr_rt`.
  - `instr_ready` does not depend on `instr_valid`.
- Writeback at the edge where the tail entry (index `LAT`) is valid and its `rd != 0`: `rf[rd] <= R0`, `status <= {overflow, zero, carry}`. `status` also updates when `rd == 0`.
- Load handshake:
  - `ld_ready = !rst` && no valid entry with `rd == ld_addr`.
  - On accept, `rf[ld_addr] <= ld_data`.
  - A load and a writeback to the same index in one cycle cannot occur, because that index is pending and the load is refused.
- An instruction and a load may both be accepted in the same edge.
  - Operands are read before the load updates `rf`: an old-value read.
- `busy` = OR of all entry valid bits.

## Timing
- Issue at edge E0. `R2`/`R3` are valid after E0. The ALU registers at E1 and the result register at E2. `R0` is sampled and written to `rf` at E0+LAT+1 (E3 for the default).
- A dependent instruction issues at E0+LAT+2 at the earliest, because the tail entry still blocks it during the writeback cycle.
- Independent instructions issue back-to-back, one per cycle.
- Reset (any cycle, including mid-operation):
  - all `rf` entries = 0, all entry valid bits = 0
  - `R2` = `R3` = 0, `ALUOp` = 0, `status` = 0
  - `instr_ready` = `ld_ready` = 0 while `rst` is high
  - in-flight results are discarded and never written back
- The first cycle after reset deasserts has `instr_ready` = `ld_ready` = 1.

## Structure
- Shared package `alu_pkg`:
  - `ALUOp` width constant (3)
  - the flag vector ordering `{overflow, zero, carry}`
  - default `WIDTH`/`LAT`
- One natural sub-module: `issue_scoreboard`, holding the in-flight shift register, the hazard compare and the writeback tail decode. The register file stays inline.

## Test plan
Benches pair `alu_issue` with a behavioural 2-stage ALU in which op `3'b000` = add.
- Reset, then load `r1=5`, `r2=7`. Issue add `r3=r1+r2` -> at E3 `rf[3]=12`, `status` zero flag = 0, `busy` drops after E3.
- Load `r1=3`. Issue add `r2=r1+r1`, then immediately add `r3=r2+r1` -> `instr_ready` = 0 for exactly 3 cycles; final `rf[3]=9`.
- Issue 4 independent adds on consecutive cycles (destinations r4–r7) -> one accept per cycle and 4 writebacks on consecutive edges, each with the correct sum.
- Issue with `rd=0`: `rf[0]` stays 0 and `dbg_data@0 = 0`; `status` still updates. A dependent read of r0 does not stall.
- Load to r5 while r5 is in flight -> `ld_ready` = 0 until the writeback edge completes, then the load is accepted and overrides the value.
- Assert `rst` one cycle after issuing `r1=r2+r3` -> no writeback occurs, all registers read 0, `busy` = 0, and `instr_ready` = 1 the cycle after `rst` falls.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode width, flag ordering and default sizing.
package alu_pkg;

    localparam int unsigned OpWidth      = 3;
    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultAw    = 3;
    localparam int unsigned DefaultLat   = 2;

    typedef enum logic [OpWidth-1:0] {
        OpAdd = 3'b000
    } alu_op_e;

    // Flag vector as written back into status: {overflow, zero, carry}.
    typedef struct packed {
        logic overflow;
        logic zero;
        logic carry;
    } flags_t;

    function automatic flags_t pack_flags(logic overflow, logic zero, logic carry);
        flags_t f;
        f.overflow = overflow;
        f.zero     = zero;
        f.carry    = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction, load and ALU-side signals of the issue stage. The slave modport is the issue
// stage; the master modport is the instruction source together with the downstream ALU.
interface alu_issue_if #(
    parameter int unsigned WIDTH = alu_pkg::DefaultWidth,
    parameter int unsigned AW    = alu_pkg::DefaultAw
);

    logic                        instr_valid;
    logic                        instr_ready;
    logic [alu_pkg::OpWidth-1:0] instr_op;
    logic [AW-1:0]               instr_rd;
    logic [AW-1:0]               instr_rs;
    logic [AW-1:0]               instr_rt;

    logic                        ld_valid;
    logic                        ld_ready;
    logic [AW-1:0]               ld_addr;
    logic [WIDTH-1:0]            ld_data;

    logic [WIDTH-1:0]            R2;
    logic [WIDTH-1:0]            R3;
    logic [alu_pkg::OpWidth-1:0] ALUOp;
    logic [WIDTH-1:0]            R0;
    logic                        overflow;
    logic                        zero;
    logic                        carry;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
        input  instr_ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        input  R2, R3, ALUOp,
        output R0, overflow, zero, carry
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
        output instr_ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        output R2, R3, ALUOp,
        input  R0, overflow, zero, carry
    );

endinterface

// File: rtl/issue_scoreboard.sv
// In-flight destination tracker: a LAT+1 deep shift register of {valid, rd}, hazard and
// load-block compares, and the writeback decode of the tail entry.
module issue_scoreboard #(
    parameter int unsigned AW  = alu_pkg::DefaultAw,
    parameter int unsigned LAT = alu_pkg::DefaultLat
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] ld_addr,
    output logic          hazard,
    output logic          ld_block,
    output logic          busy,
    output logic          wb_valid,
    output logic          wb_en,
    output logic [AW-1:0] wb_rd
);

    localparam int Depth = int'(LAT) + 1;

    logic [Depth-1:0] v_q;
    logic [AW-1:0]    rd_q [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            rd_q <= '{default: '0};
        end else begin
            v_q     <= {v_q[Depth-2:0], issue};
            rd_q[0] <= issue_rd;
            for (int i = 1; i < Depth; i++) begin
                rd_q[i] <= rd_q[i-1];
            end
        end
    end

    // The tail entry is included, so a consumer stays blocked through its writeback edge.
    always_comb begin
        hazard   = 1'b0;
        ld_block = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (v_q[i] && (rd_q[i] != '0) && ((rd_q[i] == rs) || (rd_q[i] == rt))) begin
                hazard = 1'b1;
            end
            if (v_q[i] && (rd_q[i] == ld_addr)) begin
                ld_block = 1'b1;
            end
        end
    end

    assign busy     = |v_q;
    assign wb_valid = v_q[Depth-1];
    assign wb_rd    = rd_q[Depth-1];
    assign wb_en    = wb_valid && (wb_rd != '0);

endmodule

// File: rtl/alu_issue.sv
// Operand-fetch and issue stage: register file, operand registers towards the ALU, fixed-latency
// writeback of result and flags, with issue stalled on read-after-write hazards.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned AW    = DefaultAw,
    parameter int unsigned LAT   = DefaultLat
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_if.slave       bus,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output flags_t           status,
    output logic             busy
);

    localparam int unsigned NREGS = 2 ** AW;

    logic [WIDTH-1:0]   rf_q [NREGS];
    logic [WIDTH-1:0]   r2_q;
    logic [WIDTH-1:0]   r3_q;
    logic [OpWidth-1:0] op_q;
    flags_t             status_q;

    logic          hazard;
    logic          ld_block;
    logic          issue;
    logic          ld_fire;
    logic          wb_valid;
    logic          wb_en;
    logic [AW-1:0] wb_rd;

    assign bus.instr_ready = !rst && !hazard;
    assign bus.ld_ready    = !rst && !ld_block;
    assign issue           = bus.instr_valid && bus.instr_ready;
    assign ld_fire         = bus.ld_valid && bus.ld_ready;

    issue_scoreboard #(
        .AW  (AW),
        .LAT (LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .issue_rd (bus.instr_rd),
        .rs       (bus.instr_rs),
        .rt       (bus.instr_rt),
        .ld_addr  (bus.ld_addr),
        .hazard   (hazard),
        .ld_block (ld_block),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd)
    );

    // rf_q[0] is never written, so every read of index 0 returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q     <= '{default: '0};
            r2_q     <= '0;
            r3_q     <= '0;
            op_q     <= '0;
            status_q <= '0;
        end else begin
            if (issue) begin
                r2_q <= rf_q[bus.instr_rs];
                r3_q <= rf_q[bus.instr_rt];
                op_q <= bus.instr_op;
            end
            if (wb_en) begin
                rf_q[wb_rd] <= bus.R0;
            end
            if (wb_valid) begin
                status_q <= pack_flags(bus.overflow, bus.zero, bus.carry);
            end
            // Cannot collide with wb_en: a pending destination refuses the load.
            if (ld_fire && (bus.ld_addr != '0)) begin
                rf_q[bus.ld_addr] <= bus.ld_data;
            end
        end
    end

    assign bus.R2    = r2_q;
    assign bus.R3    = r3_q;
    assign bus.ALUOp = op_q;
    assign status    = status_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule
